// File: rtl/filt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : filt_pkg
//  Brief    : Shared defaults and helpers for the sig_filter debounce block.
//  Revision : 1.0  initial release
// ============================================================================
package filt_pkg;

  // Default filter depth and synchroniser length
  localparam int FILT_STABLE_CYCLES = 4;
  localparam int FILT_SYNC_STAGES   = 2;

  // Counter width for a given filter depth. A depth of 1 would give a
  // zero-width counter, so the result is clamped to at least one bit.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage : filt_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module   : sync_chain
//  Brief    : Flop chain that brings an asynchronous bit into the clk domain.
//             All stages load RESET_VALUE on a synchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module sync_chain
  import filt_pkg::*;
#(
  parameter int   SYNC_STAGES = FILT_SYNC_STAGES,  // number of flops, >= 1
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // A single stage cannot use the shift concatenation below (the slice
  // [SYNC_STAGES-2:0] would be empty), so it gets its own branch.
  generate
    if (SYNC_STAGES == 1) begin : g_single
      // Single-flop capture of the raw input
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= RESET_VALUE;
        end else begin
          r_sync <= i_async;
        end
      end
    end else begin : g_multi
      // Shift the raw input through the chain, stage 0 first
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
      end
    end
  endgenerate

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/sig_filter.sv
`default_nettype none
// ============================================================================
//  Module   : sig_filter
//  Brief    : Glitch/debounce filter for one asynchronous input bit. The
//             output flips only after the synchronised input has shown the
//             opposite level for STABLE_CYCLES consecutive clocks.
//  Revision : 1.0  initial release
// ============================================================================
module sig_filter
  import filt_pkg::*;
#(
  parameter int   STABLE_CYCLES = FILT_STABLE_CYCLES,  // >= 1
  parameter int   SYNC_STAGES   = FILT_SYNC_STAGES,    // >= 1
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic sigout
);

  localparam int                 c_CNT_W   = cnt_width(STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

  logic               w_smp;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sigout;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk     (clock),
    .rst     (reset),
    .i_async (sig_in),
    .o_sync  (w_smp)
  );

  // Count consecutive samples that disagree with the output; flip the output
  // on the STABLE_CYCLES-th one. Any agreeing sample clears the count, so a
  // short pulse never accumulates and the counter never passes c_CNT_MAX.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sigout <= RESET_VALUE;
    end else if (w_smp == r_sigout) begin
      r_cnt    <= '0;
    end else if (r_cnt == c_CNT_MAX) begin
      r_sigout <= w_smp;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Output comes straight from the flop: no combinational path from sig_in
  assign sigout = r_sigout;

endmodule : sig_filter
`default_nettype wire

// File: tb/tb_sig_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sig_filter
//  Brief    : Self-checking bench for sig_filter. Three instances with
//             different depth/synchroniser settings share one stimulus
//             stream; a window-based reference model predicts each output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sig_filter;

  localparam int c_NCFG = 3;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       sig_in = 1'b0;
  logic [2:0] w_out;

  // Configuration table: filter depth and synchroniser length per instance
  int cfg_c [c_NCFG] = '{4, 1, 8};
  int cfg_s [c_NCFG] = '{2, 3, 1};

  always #5 clock = ~clock;

  sig_filter #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_VALUE(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .sig_in(sig_in), .sigout(w_out[0]));
  sig_filter #(.STABLE_CYCLES(1), .SYNC_STAGES(3), .RESET_VALUE(1'b0)) u_dut1 (
    .clock(clock), .reset(reset), .sig_in(sig_in), .sigout(w_out[1]));
  sig_filter #(.STABLE_CYCLES(8), .SYNC_STAGES(1), .RESET_VALUE(1'b0)) u_dut2 (
    .clock(clock), .reset(reset), .sig_in(sig_in), .sigout(w_out[2]));

  int   checks   = 0;
  int   errors   = 0;
  int   n_edge   = 0;
  int   last_rst = 0;
  logic in_hist [0:1023];
  logic [2:0] m_out = 3'b000;
  int   lat [c_NCFG];

  typedef struct {
    int         edge_no;
    logic [2:0] exp;
  } exp_t;

  exp_t sb_q [$];
  exp_t mon_e;

  // Synchronised sample seen by the filter at edge n: the input driven
  // before edge n-s, or the reset value if that precedes the last reset.
  function automatic logic smp_at(input int n, input int s);
    int j;
    j = n - s;
    if (j > last_rst) return in_hist[j];
    return 1'b0;
  endfunction

  // Drive one clock's inputs and push the model's prediction for that edge.
  // Rule: the output flips when the last C samples since reset all differ
  // from the current output value.
  task automatic step(input logic in, input logic rst);
    exp_t e;
    logic all_diff;
    @(negedge clock);
    sig_in = in;
    reset  = rst;
    n_edge++;
    if (n_edge > 1023) begin
      $display("FAIL edge_budget: got %0d edges, limit 1023", n_edge);
      $fatal(1);
    end
    in_hist[n_edge] = in;
    if (rst) begin
      m_out    = 3'b000;
      last_rst = n_edge;
    end else begin
      for (int c = 0; c < c_NCFG; c++) begin
        all_diff = ((n_edge - last_rst) >= cfg_c[c]);
        for (int k = 0; k < cfg_c[c]; k++)
          if (smp_at(n_edge - k, cfg_s[c]) == m_out[c]) all_diff = 1'b0;
        if (all_diff) m_out[c] = ~m_out[c];
      end
    end
    e.edge_no = n_edge;
    e.exp     = m_out;
    sb_q.push_back(e);
  endtask

  // Monitor: one output per edge; compare every instance against the model
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        for (int c = 0; c < c_NCFG; c++) begin
          checks++;
          if (w_out[c] !== mon_e.exp[c]) begin
            errors++;
            $display("FAIL sigout[%0d] edge %0d: got %b expected %b",
                     c, mon_e.edge_no, w_out[c], mon_e.exp[c]);
          end
        end
      end
    end
  end

  // Apply a held level and record the first edge at which each output
  // reaches it; the expected latency is SYNC_STAGES + STABLE_CYCLES.
  task automatic latency_run(input logic lvl);
    for (int c = 0; c < c_NCFG; c++) lat[c] = 0;
    for (int e = 1; e <= 20; e++) begin
      step(lvl, 1'b0);
      @(posedge clock);
      #1;
      for (int c = 0; c < c_NCFG; c++)
        if (w_out[c] === lvl && lat[c] == 0) lat[c] = e;
    end
    for (int c = 0; c < c_NCFG; c++) begin
      checks++;
      if (lat[c] != cfg_s[c] + cfg_c[c]) begin
        errors++;
        $display("FAIL latency_%0d[%0d]: got edge %0d expected edge %0d",
                 lvl, c, lat[c], cfg_s[c] + cfg_c[c]);
      end
    end
  endtask

  // Stimulus sequence
  initial begin
    // Reset with random input: outputs must sit at the reset value
    repeat (5) step(1'($urandom_range(0, 1)), 1'b1);
    repeat (12) step(1'b0, 1'b0);

    // Clean steps up and down
    latency_run(1'b1);
    latency_run(1'b0);
    repeat (4) step(1'b0, 1'b0);

    // Glitch of 3 samples (rejected by deep filters), then 4 samples
    repeat (3) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);

    // Chatter: strict toggling, then random
    for (int i = 0; i < 100; i++) step(1'(i % 2), 1'b0);
    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Reset in the middle of a count
    repeat (12) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (12) step(1'b1, 1'b0);

    // Let the monitor drain the last prediction
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sig_filter
`default_nettype wire
